alu_control_md: RTL and testbench
=================================

// Module: alu_control_md
// PURPOSE
//  EXECUTE-stage ALU control, next generation: decodes alu_op/funct to the ALU select code and
//  adds xor/nor. Also owns an iterative multiply/divide unit with HI/LO registers. Handles
//  mult/multu/div/divu/mfhi/mflo/mthi/mtlo and raises a pipeline stall while the unit is busy.
// PARAMETERS
//  DATA_W  32  operand, HI and LO width; also the mul/div iteration count
//  SEL_W   3   ALU select width; codes below use the low 3 bits, upper bits are 0
// PORTS
//  clk       in   1        single clock, rising edge
//  rst       in   1        synchronous, active-high reset
//  valid_in  in   1        EX stage holds a real instruction this cycle
//  alu_op    in   2        from main control: 00 add, 01 sub, 10 R-type (funct), 11 reserved->add
//  funct     in   6        instruction funct field
//  rs_val    in   DATA_W   operand A (multiplicand/dividend, mthi/mtlo source)
//  rt_val    in   DATA_W   operand B (multiplier/divisor)
//  select    out  SEL_W    ALU select, combinational
//  stall     out  1        hold EX and earlier stages this cycle
//  md_busy   out  1        iterative unit running
//  md_done   out  1        one-cycle pulse: HI/LO just updated by mul/div
//  hi, lo    out  DATA_W   architectural HI/LO registers
//  mf_data   out  DATA_W   mfhi -> hi, mflo -> lo, else 0 (combinational)
// BEHAVIOUR
//  - select: alu_op 00/11->010, 01->110. For 10, funct maps as follows:
//    100000/100001->010, 100010/100011->110, 100100->000, 100101->001, 100110->011,
//    100111->100, 101010/101011->111. Other funct values give 010.
//  - MD ops need alu_op=10 and valid_in. mult 011000, multu 011001, div 011010, divu 011011,
//    mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
//  - stall = valid_in & (any MD op) & md_busy. A stalled op is not accepted; it is re-presented.
//  - Accept in cycle N (MD arith op, !md_busy): operand magnitudes, sign flags and op latched.
//    md_busy=1 in cycles N+1..N+DATA_W. One radix-2 step per cycle (shift-add or restoring
//    subtract); 6-bit counter runs 0..DATA_W-1.
//  - Edge ending cycle N+DATA_W writes the sign-corrected result to HI/LO. In cycle N+DATA_W+1:
//    md_busy=0, md_done=1, and new HI/LO are visible.
//  - mult/multu: {hi,lo} = full 2*DATA_W product. Signed mode negates when the sign flags differ.
//  - div/divu: lo=quotient, hi=remainder. Signed: quotient truncates toward zero; remainder takes
//    the sign of the dividend.
//  - Divide by zero: hi=rs_val, lo=all ones; still takes the full DATA_W cycles.
//  - Signed overflow (MIN_INT / -1): lo=MIN_INT, hi=0.
//  - mthi/mtlo accepted when !md_busy: HI or LO <= rs_val at the edge ending the accept cycle.
//  - mfhi/mflo while busy: stall. Read is valid from the md_done cycle onward.
//  - An ALU op (non-MD) in EX while busy: no stall; select is valid as normal.
//  - valid_in=0: nothing accepted, stall=0.
//  - Reset (incl. mid-operation): hi=lo=0, md_busy=0, md_done=0, counter=0, in-flight op dropped.
//    stall=0 in the cycle after reset.
// STRUCTURE
//  - alu_defs.vh (shared include): ALU select codes, funct codes, alu_op codes.
//  - Sub-module md_iter: iterative mul/div datapath plus counter. Ports: start, is_div,
//    a_mag, b_mag, busy, last, p_hi, p_lo.
//  - Top level holds: decode, sign pre/post-correction, HI/LO registers, stall logic.
// TESTING  (DATA_W=32)
//  1. Decode sweep: alu_op 00/01 with funct 100000 -> 010/110. alu_op 10 with funct
//     100000/100010/100100/100101/101010/100110/100111 -> 010/110/000/001/111/011/100.
//  2. mult 0xFFFFFFFD*7 -> after 33 cycles hi=FFFFFFFF, lo=FFFFFFEB, md_done pulse.
//     multu with the same operands -> hi=00000006, lo=FFFFFFEB.
//  3. div -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF. divu 100/7 -> lo=0000000E, hi=00000002.
//  4. mflo presented 1 cycle after a mult accept -> stall=1 for 32 cycles. In the md_done cycle
//     stall=0 and mf_data=new lo. An add in EX while busy: select=010, stall=0.
//  5. div 5/0 -> hi=00000005, lo=FFFFFFFF. div 80000000/FFFFFFFF -> lo=80000000, hi=0.
//     mthi 0x1234 while idle -> hi=00001234 next cycle.
//  6. rst asserted in busy cycle 10 -> next cycle md_busy=0, hi=lo=0, no md_done.
//     A following mult then completes normally.

Source files
------------

// File: rtl/alu_control_md_pkg.sv
// Shared ALU/MD decode constants, decoded-op payload and decode helpers for alu_control_md.
package alu_control_md_pkg;

  localparam int unsigned MD_CNT_W = 6;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_XOR = 3'b011;
  localparam logic [2:0] SEL_NOR = 3'b100;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef struct packed {
    logic is_md;
    logic arith;
    logic is_div;
    logic is_signed;
    logic mthi;
    logic mtlo;
    logic mfhi;
    logic mflo;
  } md_dec_t;

  function automatic md_dec_t decode_md(input logic [5:0] f);
    md_dec_t d;
    d = '0;
    case (f)
      FN_MULT:  begin d.is_md = 1'b1; d.arith = 1'b1; d.is_signed = 1'b1; end
      FN_MULTU: begin d.is_md = 1'b1; d.arith = 1'b1; end
      FN_DIV:   begin d.is_md = 1'b1; d.arith = 1'b1; d.is_div = 1'b1; d.is_signed = 1'b1; end
      FN_DIVU:  begin d.is_md = 1'b1; d.arith = 1'b1; d.is_div = 1'b1; end
      FN_MFHI:  begin d.is_md = 1'b1; d.mfhi = 1'b1; end
      FN_MTHI:  begin d.is_md = 1'b1; d.mthi = 1'b1; end
      FN_MFLO:  begin d.is_md = 1'b1; d.mflo = 1'b1; end
      FN_MTLO:  begin d.is_md = 1'b1; d.mtlo = 1'b1; end
      default:  d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] alu_select(input logic [1:0] op, input logic [5:0] f);
    logic [2:0] s;
    s = SEL_ADD;
    if (op == ALU_OP_SUB) begin
      s = SEL_SUB;
    end else if (op == ALU_OP_RTYPE) begin
      case (f)
        FN_ADD, FN_ADDU: s = SEL_ADD;
        FN_SUB, FN_SUBU: s = SEL_SUB;
        FN_AND:          s = SEL_AND;
        FN_OR:           s = SEL_OR;
        FN_XOR:          s = SEL_XOR;
        FN_NOR:          s = SEL_NOR;
        FN_SLT, FN_SLTU: s = SEL_SLT;
        default:         s = SEL_ADD;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/alu_control_md_md_iter.sv
// Iterative unsigned radix-2 multiply (shift-add) / divide (restoring) on magnitudes.
// p_hi/p_lo present the result of this cycle's step; the final step's values are the result.
module alu_control_md_md_iter
  import alu_control_md_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a_mag,
  input  logic [DATA_W-1:0] b_mag,
  output logic              busy,
  output logic              last,
  output logic [DATA_W-1:0] p_hi,
  output logic [DATA_W-1:0] p_lo
);

  logic [MD_CNT_W-1:0] count;
  logic                div_mode;
  logic [DATA_W-1:0]   w_hi;
  logic [DATA_W-1:0]   w_lo;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     shifted;

  assign last = busy && (count == MD_CNT_W'(DATA_W - 1));

  // One step: w_hi is accumulator/remainder, w_lo is multiplier/quotient.
  always_comb begin
    sum     = '0;
    shifted = '0;
    p_hi    = w_hi;
    p_lo    = w_lo;
    if (div_mode) begin
      shifted = {w_hi, w_lo[DATA_W-1]};
      if (shifted >= {1'b0, opnd}) begin
        sum  = shifted - {1'b0, opnd};
        p_hi = sum[DATA_W-1:0];
        p_lo = {w_lo[DATA_W-2:0], 1'b1};
      end else begin
        p_hi = shifted[DATA_W-1:0];
        p_lo = {w_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : '0);
      p_hi = sum[DATA_W:1];
      p_lo = {sum[0], w_lo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      count    <= '0;
      div_mode <= 1'b0;
      w_hi     <= '0;
      w_lo     <= '0;
      opnd     <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      count    <= '0;
      div_mode <= is_div;
      w_hi     <= '0;
      w_lo     <= is_div ? a_mag : b_mag;
      opnd     <= is_div ? b_mag : a_mag;
    end else if (busy) begin
      w_hi  <= p_hi;
      w_lo  <= p_lo;
      count <= last ? '0 : count + MD_CNT_W'(1);
      if (last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_control_md.sv
// EX-stage ALU select decode plus iterative mult/div unit with HI/LO and pipeline stall.
module alu_control_md
  import alu_control_md_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [SEL_W-1:0]  select,
  output logic              stall,
  output logic              md_busy,
  output logic              md_done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] mf_data
);

  md_dec_t             dec;
  logic                md_op;
  logic                accept;
  logic                start;
  logic                last;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   p_hi;
  logic [DATA_W-1:0]   p_lo;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;
  logic [DATA_W-1:0]   raw_a;
  logic [2*DATA_W-1:0] prod;
  logic                neg_a;
  logic                neg_b;
  logic                op_div;
  logic                div_zero;

  // Decode, stall and operand magnitude pre-correction.
  always_comb begin
    dec     = decode_md(funct);
    md_op   = valid_in && (alu_op == ALU_OP_RTYPE) && dec.is_md;
    stall   = md_op && md_busy;
    accept  = md_op && !md_busy;
    start   = accept && dec.arith;
    select  = SEL_W'(alu_select(alu_op, funct));
    a_mag   = (dec.is_signed && rs_val[DATA_W-1]) ? -rs_val : rs_val;
    b_mag   = (dec.is_signed && rt_val[DATA_W-1]) ? -rt_val : rt_val;
    mf_data = '0;
    if (md_op && dec.mfhi) begin
      mf_data = hi;
    end else if (md_op && dec.mflo) begin
      mf_data = lo;
    end
  end

  alu_control_md_md_iter #(
    .DATA_W(DATA_W)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .is_div(dec.is_div),
    .a_mag (a_mag),
    .b_mag (b_mag),
    .busy  (md_busy),
    .last  (last),
    .p_hi  (p_hi),
    .p_lo  (p_lo)
  );

  // Sign post-correction; divide-by-zero returns the raw dividend in HI.
  always_comb begin
    prod = {p_hi, p_lo};
    if (neg_a ^ neg_b) begin
      prod = -prod;
    end
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (op_div) begin
      if (div_zero) begin
        res_hi = raw_a;
        res_lo = '1;
      end else begin
        res_lo = (neg_a ^ neg_b) ? -p_lo : p_lo;
        res_hi = neg_a ? -p_hi : p_hi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      md_done  <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
    end else begin
      md_done <= last;
      if (start) begin
        neg_a    <= dec.is_signed && rs_val[DATA_W-1];
        neg_b    <= dec.is_signed && rt_val[DATA_W-1];
        op_div   <= dec.is_div;
        div_zero <= (rt_val == '0);
        raw_a    <= rs_val;
      end
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (accept) begin
        if (dec.mthi) hi <= rs_val;
        if (dec.mtlo) lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// Randomized and directed bench for alu_control_md against an arithmetic reference model.
module tb_alu_control_md;

  localparam int unsigned W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [2:0]  select;
  logic        stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  alu_control_md #(.DATA_W(32), .SEL_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .valid_in(valid_in),
    .alu_op  (alu_op),
    .funct   (funct),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .select  (select),
    .stall   (stall),
    .md_busy (md_busy),
    .md_done (md_done),
    .hi      (hi),
    .lo      (lo),
    .mf_data (mf_data)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  logic        done_exp = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] pend = 64'd0;
  logic        stall_s;
  logic [2:0]  sel_s;
  logic [31:0] mf_s;

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          q;
    int          r;
    if (f == 6'b011000) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return 64'(sp);
    end
    if (f == 6'b011001) begin
      up = {32'd0, a} * {32'd0, b};
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (f == 6'b011010) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [2:0] ref_sel(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return 3'b110;
    if (op != 2'b10) return 3'b010;
    case (f)
      6'h20, 6'h21: return 3'b010;
      6'h22, 6'h23: return 3'b110;
      6'h24:        return 3'b000;
      6'h25:        return 3'b001;
      6'h26:        return 3'b011;
      6'h27:        return 3'b100;
      6'h2A, 6'h2B: return 3'b111;
      default:      return 3'b010;
    endcase
  endfunction

  function automatic logic is_md(input logic v, input logic [1:0] op, input logic [5:0] f);
    return v && op == 2'b10 &&
           (f inside {6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13});
  endfunction

  // Model state advances on each rising edge from the inputs held in that cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_hi     <= 32'd0;
      m_lo     <= 32'd0;
      busy_cnt <= 0;
      done_exp <= 1'b0;
    end else begin
      done_exp <= (busy_cnt == 1);
      if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          m_hi <= pend[63:32];
          m_lo <= pend[31:0];
        end
      end else if (valid_in && alu_op == 2'b10) begin
        if (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B}) begin
          pend     <= ref_md(funct, rs_val, rt_val);
          busy_cnt <= int'(W);
        end else if (funct == 6'h11) begin
          m_hi <= rs_val;
        end else if (funct == 6'h13) begin
          m_lo <= rs_val;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic        exp_stall;
    logic        md;
    logic [31:0] exp_mf;
    md        = is_md(valid_in, alu_op, funct);
    exp_stall = md && (busy_cnt > 0);
    chk("select", 64'(select), 64'(ref_sel(alu_op, funct)));
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("md_busy", 64'(md_busy), 64'(busy_cnt > 0));
    chk("md_done", 64'(md_done), 64'(done_exp));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    if (!exp_stall) begin
      exp_mf = 32'd0;
      if (md && funct == 6'h10) exp_mf = m_hi;
      if (md && funct == 6'h12) exp_mf = m_lo;
      chk("mf_data", 64'(mf_data), 64'(exp_mf));
    end
  endtask

  task automatic tick(input logic v, input logic [1:0] op, input logic [5:0] f,
                      input logic [31:0] a, input logic [31:0] b, input logic r);
    rst = r; valid_in = v; alu_op = op; funct = f; rs_val = a; rt_val = b;
    @(negedge clk);
    compare();
    stall_s = stall;
    sel_s   = select;
    mf_s    = mf_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    tick(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    tick(1'b1, 2'b10, f, a, b, 1'b0);
    repeat (W) idle();
    chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({name, "_done"}, 64'(md_done), 64'd1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [1:0] dec_op  [9] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
  logic [5:0] dec_fn  [9] = '{6'h20, 6'h20, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26, 6'h27};
  logic [2:0] dec_exp [9] = '{3'b010, 3'b110, 3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011, 3'b100};
  logic [5:0] rnd_fn  [15] = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13,
                               6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_st;
    logic       r;
    logic       v;
    logic [1:0] op;
    logic [5:0] f;
    int         k;

    tick(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b1);
    tick(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b1);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_busy", 64'(md_busy), 64'd0);

    chk("model_mult", ref_md(6'h18, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_div", ref_md(6'h1A, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);

    for (int i = 0; i < 9; i++) begin
      tick(1'b1, dec_op[i], dec_fn[i], 32'd1, 32'd2, 1'b0);
      chk($sformatf("decode_%0d", i), 64'(sel_s), 64'(dec_exp[i]));
    end

    run_md("mult", 6'h18, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("multu", 6'h19, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 32'hFFFF_FFEB);
    run_md("div", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu", 6'h1B, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);

    // mflo waiting on a busy multiply
    tick(1'b1, 2'b10, 6'h18, 32'hFFFF_FFFD, 32'd7, 1'b0);
    n_st = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 2'b10, 6'h12, 32'd0, 32'd0, 1'b0);
      if (!stall_s) break;
      n_st++;
    end
    chk("mflo_stall_cycles", 64'(n_st), 64'd32);
    chk("mflo_data", 64'(mf_s), 64'hFFFF_FFEB);

    tick(1'b1, 2'b10, 6'h19, 32'd5, 32'd6, 1'b0);
    tick(1'b1, 2'b00, 6'h20, 32'd0, 32'd0, 1'b0);
    chk("add_busy_sel", 64'(sel_s), 64'd2);
    chk("add_busy_stall", 64'(stall_s), 64'd0);
    repeat (W - 1) idle();
    chk("multu_small_lo", 64'(lo), 64'd30);

    run_md("div0", 6'h1A, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF);
    run_md("divovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    tick(1'b1, 2'b10, 6'h11, 32'h0000_1234, 32'd0, 1'b0);
    chk("mthi", 64'(hi), 64'h0000_1234);

    // reset in busy cycle 10
    tick(1'b1, 2'b10, 6'h18, 32'h10, 32'h10, 1'b0);
    repeat (9) idle();
    tick(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 1'b1);
    chk("rst_mid_busy", 64'(md_busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    repeat (30) idle();
    run_md("mult_after_rst", 6'h18, 32'd3, 32'd5, 32'd0, 32'd15);

    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      k  = int'($urandom_range(0, 16));
      f  = (k < 15) ? rnd_fn[k] : 6'($urandom_range(0, 63));
      tick(v, op, f, pick_val(), pick_val(), r);
    end
    repeat (40) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
